// File: rtl/ram_port_arbiter_pkg.sv
// Shared encodings for the RAM port arbiter: access sizes and arbiter states.
package ram_port_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

    // Misaligned halves/words and the reserved size code never reach the RAM.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
        logic e;
        e = 1'b0;
        case (size)
            SZ_BYTE: e = 1'b0;
            SZ_HALF: e = off[0];
            SZ_WORD: e = (off != 2'b00);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ram_lane_align.sv
// Byte-lane strobe/write replication and load extraction for a 32-bit byte-lane RAM.
module ram_lane_align
    import ram_port_arbiter_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  lane_o,
    output logic        err_o,
    output logic [31:0] wdata_o,
    input  logic [31:0] ld_data_i,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] shifted;

    assign err_o = access_err(size_i, off_i);

    always_comb begin
        lane_o  = 4'b0000;
        wdata_o = '0;
        if (!err_o) begin
            case (size_i)
                SZ_BYTE: begin
                    lane_o  = 4'b0001 << off_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                SZ_HALF: begin
                    lane_o  = off_i[1] ? 4'b1100 : 4'b0011;
                    wdata_o = {2{wdata_i[15:0]}};
                end
                default: begin
                    lane_o  = 4'b1111;
                    wdata_o = wdata_i;
                end
            endcase
        end
    end

    // Little-endian: the addressed byte lands in bits [7:0] after the shift.
    assign shifted = ld_data_i >> {ld_off_i, 3'b000};

    always_comb begin
        ld_data_o = shifted;
        case (ld_size_i)
            SZ_BYTE: ld_data_o = ld_unsigned_i ? {24'h0, shifted[7:0]}
                                               : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: ld_data_o = ld_unsigned_i ? {16'h0, shifted[15:0]}
                                               : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin instruction/data arbiter driving a single-ported byte-lane synchronous RAM.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [31:0]           i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [1:0]            d_size,
    input  logic                  d_unsigned,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    output logic                  d_err,
    output logic [ADDR_WIDTH-3:0] ram_addr,
    output logic [3:0]            ram_cs_n,
    output logic [3:0]            ram_we_n,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    localparam int         WA = ADDR_WIDTH - 2;
    localparam logic [1:0] WS = 2'(WAIT_STATES);

    arb_state_e    state_q;
    logic [1:0]    wait_q;
    logic          last_data_q;
    logic          i_pend_q;
    logic          i_rvalid_q;
    logic          d_rvalid_q;
    logic          err_q;
    logic          we_q;
    logic          uns_q;
    logic [1:0]    size_q;
    logic [1:0]    off_q;
    logic [WA-1:0] addr_q;
    logic [3:0]    cs_n_q;
    logic [3:0]    we_n_q;
    logic [31:0]   wdata_q;

    logic [WA-1:0] addr_d;
    logic [3:0]    cs_n_d;
    logic [3:0]    we_n_d;
    logic [31:0]   wdata_d;

    logic          can_grant;
    logic [3:0]    lane;
    logic          d_err_c;
    logic [31:0]   rep_wdata;
    logic [31:0]   ld_data;
    logic          unused_iaddr_lsb;

    // Fetches are always whole words; the low address bits carry no meaning.
    assign unused_iaddr_lsb = ^i_addr[1:0];

    ram_lane_align u_align (
        .size_i        (d_size),
        .off_i         (d_addr[1:0]),
        .wdata_i       (d_wdata),
        .lane_o        (lane),
        .err_o         (d_err_c),
        .wdata_o       (rep_wdata),
        .ld_data_i     (ram_rdata),
        .ld_size_i     (size_q),
        .ld_off_i      (off_q),
        .ld_unsigned_i (uns_q),
        .ld_data_o     (ld_data)
    );

    // Gating with rst_n keeps grants (and thus RAM strobes) quiet while in reset.
    assign can_grant = rst_n && (state_q != ST_HOLD) && (wait_q == 2'd0);
    assign d_gnt     = can_grant && d_req && (!i_req || !last_data_q);
    assign i_gnt     = can_grant && i_req && !d_gnt;

    always_comb begin
        addr_d  = '0;
        cs_n_d  = 4'hF;
        we_n_d  = 4'hF;
        wdata_d = '0;
        if (d_gnt) begin
            addr_d = d_addr[ADDR_WIDTH-1:2];
            cs_n_d = ~lane;
            if (d_we && !d_err_c) begin
                we_n_d  = ~lane;
                wdata_d = rep_wdata;
            end
        end else if (i_gnt) begin
            addr_d = i_addr[ADDR_WIDTH-1:2];
            cs_n_d = 4'h0;
        end
    end

    assign ram_addr  = (state_q == ST_HOLD) ? addr_q  : addr_d;
    assign ram_cs_n  = (state_q == ST_HOLD) ? cs_n_q  : cs_n_d;
    assign ram_we_n  = (state_q == ST_HOLD) ? we_n_q  : we_n_d;
    assign ram_wdata = (state_q == ST_HOLD) ? wdata_q : wdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wait_q      <= 2'd0;
            last_data_q <= 1'b0;
            i_pend_q    <= 1'b0;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= SZ_BYTE;
            off_q       <= 2'd0;
            addr_q      <= '0;
            cs_n_q      <= 4'hF;
            we_n_q      <= 4'hF;
            wdata_q     <= '0;
        end else begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            case (state_q)
                ST_HOLD: begin
                    if (wait_q == 2'd1) begin
                        state_q    <= ST_RESP;
                        wait_q     <= 2'd0;
                        i_rvalid_q <= i_pend_q;
                        d_rvalid_q <= !i_pend_q;
                    end else begin
                        wait_q <= wait_q - 2'd1;
                    end
                end
                default: begin
                    if (i_gnt || d_gnt) begin
                        last_data_q <= d_gnt;
                        i_pend_q    <= i_gnt;
                        err_q       <= d_gnt && d_err_c;
                        we_q        <= d_gnt && d_we;
                        uns_q       <= d_unsigned;
                        size_q      <= d_size;
                        off_q       <= d_addr[1:0];
                        addr_q      <= addr_d;
                        cs_n_q      <= cs_n_d;
                        we_n_q      <= we_n_d;
                        wdata_q     <= wdata_d;
                        // Rejected data accesses answer immediately; nothing to wait for.
                        if (WS == 2'd0 || (d_gnt && d_err_c)) begin
                            state_q    <= ST_RESP;
                            i_rvalid_q <= i_gnt;
                            d_rvalid_q <= d_gnt;
                        end else begin
                            state_q <= ST_HOLD;
                            wait_q  <= WS;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign i_rvalid = i_rvalid_q;
    assign i_rdata  = i_rvalid_q ? ram_rdata : '0;
    assign d_rvalid = d_rvalid_q;
    assign d_err    = d_rvalid_q && err_q;
    assign d_rdata  = (d_rvalid_q && !err_q && !we_q) ? ld_data : '0;

endmodule
